// File: rtl/key_debounce_pulser.sv
// key_debounce_pulser: per-key synchroniser and debounce FSM for active-low pushbuttons,
// producing a clean level plus one-cycle press, release and auto-repeat pulses.
module key_debounce_pulser #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);
  localparam logic [CW-1:0] CTOP = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD   = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP   = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit REN = REPEAT_DELAY > 0;
  typedef enum logic [1:0] {RELEASED, DB_PRESS, PRESSED, DB_RELEASE} state_t;
  logic [NUM_KEYS-1:0] s1, s2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ~key_n;
      s2 <= s1;
    end
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t st;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    logic rep, level, press, release_p, repeat_p;
    // rep selects the repeat period once the initial delay has elapsed
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st        <= RELEASED;
        cnt       <= '0;
        rcnt      <= '0;
        rep       <= 1'b0;
        level     <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
        repeat_p  <= 1'b0;
      end else begin
        press     <= 1'b0;
        release_p <= 1'b0;
        repeat_p  <= 1'b0;
        case (st)
          RELEASED:
            if (s2[k]) begin
              st  <= DB_PRESS;
              cnt <= '0;
            end
          DB_PRESS:
            if (!s2[k]) st <= RELEASED;
            else if (cnt == CTOP) begin
              st    <= PRESSED;
              rcnt  <= '0;
              rep   <= 1'b0;
              press <= 1'b1;
              level <= 1'b1;
            end else cnt <= cnt + 1'b1;
          PRESSED:
            if (!s2[k]) begin
              st  <= DB_RELEASE;
              cnt <= '0;
            end else if (REN) begin
              if (rcnt == (rep ? RP : RD)) begin
                rcnt     <= '0;
                rep      <= 1'b1;
                repeat_p <= 1'b1;
              end else rcnt <= rcnt + 1'b1;
            end
          default:
            if (s2[k]) begin
              st   <= PRESSED;
              rcnt <= '0;
              rep  <= 1'b0;
            end else if (cnt == CTOP) begin
              st        <= RELEASED;
              release_p <= 1'b1;
              level     <= 1'b0;
            end else cnt <= cnt + 1'b1;
        endcase
      end
    assign key_level[k]   = level;
    assign key_press[k]   = press;
    assign key_release[k] = release_p;
    assign key_repeat[k]  = repeat_p;
  end
endmodule

// File: tb/tb_key_debounce_pulser.sv
// tb_key_debounce_pulser: directed checks of debounce latency, glitch rejection, repeat and reset.
module tb_key_debounce_pulser;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] key_n, key_level, key_press, key_release, key_repeat;
  int tests = 0;
  int fails = 0;
  key_debounce_pulser #(
    .NUM_KEYS(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    key_n = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      tick();
      tests++;
      if ({key_level, key_press, key_release, key_repeat} !== 8'h00) begin
        fails++;
        $display("FAIL reset k=%0d outputs=%b expected=00000000", k, {key_level, key_press, key_release, key_repeat});
      end
    end
    rst = 1'b0;
    repeat (3) tick();
  endtask
  task automatic test_press_release();
    key_n[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests++;
      if (key_press !== {1'b0, k == 7} || key_level !== {1'b0, k >= 7} || key_repeat !== 2'b00) begin
        fails++;
        $display("FAIL press k=%0d press=%b level=%b repeat=%b expected press=%b level=%b", k, key_press, key_level, key_repeat, {1'b0, k == 7}, {1'b0, k >= 7});
      end
    end
    key_n[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests++;
      if (key_release !== {1'b0, k == 7} || key_level !== {1'b0, k < 7} || key_press !== 2'b00) begin
        fails++;
        $display("FAIL release k=%0d release=%b level=%b press=%b expected release=%b level=%b", k, key_release, key_level, key_press, {1'b0, k == 7}, {1'b0, k < 7});
      end
    end
  endtask
  task automatic test_glitch();
    key_n[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) key_n[0] = 1'b1;
      tests++;
      if ({key_level, key_press, key_release, key_repeat} !== 8'h00) begin
        fails++;
        $display("FAIL glitch4 k=%0d outputs=%b expected=00000000", k, {key_level, key_press, key_release, key_repeat});
      end
    end
    key_n[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5) key_n[0] = 1'b1;
      tests++;
      if (key_press !== {1'b0, k == 7} || key_release !== {1'b0, k == 12} || key_level !== {1'b0, k >= 7 && k < 12}) begin
        fails++;
        $display("FAIL glitch5 k=%0d press=%b release=%b level=%b expected press=%b release=%b level=%b", k, key_press, key_release, key_level, {1'b0, k == 7}, {1'b0, k == 12}, {1'b0, k >= 7 && k < 12});
      end
    end
  endtask
  task automatic test_repeat();
    logic er;
    key_n[1] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 37) key_n[1] = 1'b1;
      if (k == 39) key_n[1] = 1'b0;
      er = (k >= 15 && k <= 39 && (k - 15) % 3 == 0) || (k >= 50 && (k - 50) % 3 == 0);
      tests++;
      if (key_repeat !== {er, 1'b0} || key_press !== {k == 7, 1'b0} || key_release !== 2'b00 || key_level !== {k >= 7, 1'b0}) begin
        fails++;
        $display("FAIL repeat k=%0d repeat=%b press=%b release=%b level=%b expected repeat=%b press=%b", k, key_repeat, key_press, key_release, key_level, {er, 1'b0}, {k == 7, 1'b0});
      end
    end
    key_n[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      tests++;
      if (key_release !== {k == 7, 1'b0} || key_repeat !== {k == 2, 1'b0}) begin
        fails++;
        $display("FAIL repeat_release k=%0d release=%b repeat=%b expected release=%b repeat=%b", k, key_release, key_repeat, {k == 7, 1'b0}, {k == 2, 1'b0});
      end
    end
  endtask
  task automatic test_back_to_back();
    key_n = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests++;
      if (key_press !== {2{k == 7}}) begin
        fails++;
        $display("FAIL both_press k=%0d press=%b expected=%b", k, key_press, {2{k == 7}});
      end
    end
    key_n = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      tick();
      tests++;
      if (key_release !== {2{k == 7}}) begin
        fails++;
        $display("FAIL both_release k=%0d release=%b expected=%b", k, key_release, {2{k == 7}});
      end
    end
  endtask
  task automatic test_reset_mid();
    key_n[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    tests++;
    if ({key_level, key_press, key_release, key_repeat} !== 8'h00) begin
      fails++;
      $display("FAIL rst_async outputs=%b expected=00000000", {key_level, key_press, key_release, key_repeat});
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      tests++;
      if ({key_level, key_press, key_release, key_repeat} !== 8'h00) begin
        fails++;
        $display("FAIL rst_mid k=%0d outputs=%b expected=00000000", k, {key_level, key_press, key_release, key_repeat});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests++;
      if (key_press !== {1'b0, k == 7} || key_release !== 2'b00) begin
        fails++;
        $display("FAIL rst_repress k=%0d press=%b release=%b expected press=%b", k, key_press, key_release, {1'b0, k == 7});
      end
    end
  endtask
  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_repeat();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
